// File: rtl/itof_pipe_if.sv
// Handshake bundle for the integer-to-float converter: an operand channel
// (in_*) flowing into the block and a result channel (out_*) flowing out.
// The master modport is the side that produces operands and consumes results.
interface itof_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/itof_pipe.sv
// Two-stage signed 32-bit integer to IEEE-754 binary32 converter.
// Stage 1 splits the operand into sign, magnitude, zero flag and leading-zero
// count. Stage 2 normalises, rounds to nearest-even and packs the result.
// Both stages advance independently under a valid/ready handshake, giving one
// conversion per cycle when the consumer keeps up.
module itof_pipe (
    input  logic       clk,
    input  logic       rst,
    itof_pipe_if.slave bus_io
);

    localparam int          DATA_W  = 32;
    localparam logic [7:0]  EXP_TOP = 8'd158;   // biased exponent of 2^31

    // Magnitude as an unsigned value; -2^31 maps to 32'h80000000.
    function automatic logic [DATA_W-1:0] abs_mag(input logic signed [DATA_W-1:0] v);
        logic [DATA_W-1:0] u;
        u = $unsigned(v);
        if (v[DATA_W-1]) begin
            return ~u + 32'd1;
        end
        return u;
    endfunction

    // Leading-zero count; result is irrelevant for a zero operand.
    function automatic logic [4:0] lzc32(input logic [DATA_W-1:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(DATA_W - 1 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // Normalise, round to nearest-even and pack into binary32.
    function automatic logic [31:0] round_pack(
        input logic              sign,
        input logic              zero,
        input logic [DATA_W-1:0] mag,
        input logic [4:0]        lz
    );
        logic [30:0] frac;      // normalised value with the implicit one dropped
        logic [22:0] mant;
        logic [23:0] mant_inc;
        logic        guard;
        logic        sticky;
        logic        lsb;
        logic        inc;
        logic [7:0]  exp;
        frac     = 31'(mag << lz);
        mant     = frac[30:8];
        lsb      = frac[8];
        guard    = frac[7];
        sticky   = |frac[6:0];
        inc      = guard & (sticky | lsb);
        mant_inc = {1'b0, mant} + {23'd0, inc};
        exp      = EXP_TOP - {3'd0, lz};
        // A carry out of the mantissa means the value rounded up to the next
        // power of two: mantissa wraps to zero and the exponent steps up.
        if (mant_inc[23]) begin
            mant = 23'd0;
            exp  = exp + 8'd1;
        end else begin
            mant = mant_inc[22:0];
        end
        if (zero) begin
            return 32'h0000_0000;
        end
        return {sign, exp, mant};
    endfunction

    logic adv1;
    logic adv2;

    logic              vld_p1_q, vld_p1_d;
    logic              sign_p1_q, sign_p1_d;
    logic              zero_p1_q, zero_p1_d;
    logic [DATA_W-1:0] mag_p1_q, mag_p1_d;
    logic [4:0]        lz_p1_q, lz_p1_d;

    logic              vld_p2_q, vld_p2_d;
    logic [31:0]       res_p2_q, res_p2_d;

    logic signed [DATA_W-1:0] opnd;
    logic        [DATA_W-1:0] opnd_mag;

    assign opnd     = $signed(bus_io.in_data);
    assign opnd_mag = abs_mag(opnd);

    // A stage may load when it is empty or its contents move on this cycle;
    // in_ready never looks at in_valid.
    assign adv2            = ~vld_p2_q | bus_io.out_ready;
    assign adv1            = ~vld_p1_q | adv2;
    assign bus_io.in_ready = adv1;

    // ---- stage 1 boundary: operand decomposition ----
    // Next-state for the first stage: capture on adv1, otherwise hold.
    always_comb begin
        vld_p1_d  = vld_p1_q;
        sign_p1_d = sign_p1_q;
        zero_p1_d = zero_p1_q;
        mag_p1_d  = mag_p1_q;
        lz_p1_d   = lz_p1_q;
        if (adv1) begin
            vld_p1_d  = bus_io.in_valid;
            sign_p1_d = opnd[DATA_W-1];
            zero_p1_d = (opnd == '0);
            mag_p1_d  = opnd_mag;
            lz_p1_d   = lzc32(opnd_mag);
        end
    end

    // ---- stage 2 boundary: normalise, round, pack ----
    // Next-state for the second stage: capture on adv2, otherwise hold.
    always_comb begin
        vld_p2_d = vld_p2_q;
        res_p2_d = res_p2_q;
        if (adv2) begin
            vld_p2_d = vld_p1_q;
            res_p2_d = round_pack(sign_p1_q, zero_p1_q, mag_p1_q, lz_p1_q);
        end
    end

    // Stage valid flags; reset drops any conversion in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
        end
    end

    // Stage data registers; their contents only matter while the valid is set.
    always_ff @(posedge clk) begin
        sign_p1_q <= sign_p1_d;
        zero_p1_q <= zero_p1_d;
        mag_p1_q  <= mag_p1_d;
        lz_p1_q   <= lz_p1_d;
        res_p2_q  <= res_p2_d;
    end

    // Result is forced to zero when nothing valid is held, which also gives
    // the zero value after reset without resetting the data register.
    assign bus_io.out_valid = vld_p2_q;
    assign bus_io.out_data  = vld_p2_q ? res_p2_q : 32'h0000_0000;

endmodule

// File: tb/tb_itof_pipe.sv
// Self-checking bench for itof_pipe: directed values, rounding ties,
// extremes, backpressure, reset mid-stream and a randomised stream, with a
// scoreboard queue of expected results in acceptance order.
module tb_itof_pipe;

    typedef struct {
        logic [31:0] exp;
        int          cyc;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    item_t sb[$];

    itof_pipe_if bus ();

    itof_pipe dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Independent reference: go through an exact double, then round its
    // 52-bit fraction down to 23 bits with ties to even.
    function automatic logic [31:0] ref_itof(input logic [31:0] x);
        real         r;
        logic [63:0] d;
        logic [10:0] e;
        logic [51:0] m;
        logic [22:0] mant;
        logic [23:0] sum;
        logic [7:0]  ex;
        logic        g, s, l;
        if (x == 32'd0) return 32'd0;
        r    = $itor($signed(x));
        d    = $realtobits(r);
        e    = d[62:52];
        m    = d[51:0];
        ex   = 8'(e - 11'd896);
        mant = m[51:29];
        l    = m[29];
        g    = m[28];
        s    = |m[27:0];
        sum  = {1'b0, mant} + ((g & (s | l)) ? 24'd1 : 24'd0);
        if (sum[23]) begin
            mant = 23'd0;
            ex   = ex + 8'd1;
        end else begin
            mant = sum[22:0];
        end
        return {d[63], ex, mant};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'd0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        checks++;
        if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h want 00000000", bus.out_data); end
    endtask

    task automatic test_basic();
        logic [31:0] vals[4];
        logic [31:0] exps[4];
        item_t it;
        int idx = 0;
        int guard = 0;
        vals = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'd3};
        exps = '{32'h0000_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h4040_0000};
        sb.delete();
        while ((idx < 4 || sb.size() > 0) && guard < 50) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            bus.in_valid  = (idx < 4);
            bus.in_data   = (idx < 4) ? vals[idx] : 32'd0;
            #1;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL basic_spurious: got %h want none", bus.out_data);
                end else begin
                    it = sb.pop_front();
                    if (bus.out_data !== it.exp) begin errors++; $display("FAIL basic_value: got %h want %h", bus.out_data, it.exp); end
                    checks++;
                    if (cyc - it.cyc != 2) begin errors++; $display("FAIL basic_latency: got %0d want 2", cyc - it.cyc); end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back('{exps[idx], cyc});
                idx++;
            end
            guard++;
        end
        checks++;
        if (guard >= 50) begin errors++; $display("FAIL basic_timeout: got %0d pending want 0", sb.size()); end
    endtask

    task automatic test_rounding();
        logic [31:0] vals[4];
        logic [31:0] exps[4];
        item_t it;
        int idx = 0;
        int guard = 0;
        vals = '{32'd16777217, 32'd16777219, 32'd16777221, 32'd2};
        exps = '{32'h4B80_0000, 32'h4B80_0002, 32'h4B80_0002, 32'h4000_0000};
        sb.delete();
        while ((idx < 4 || sb.size() > 0) && guard < 50) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            bus.in_valid  = (idx < 4);
            bus.in_data   = (idx < 4) ? vals[idx] : 32'd0;
            #1;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL round_spurious: got %h want none", bus.out_data);
                end else begin
                    it = sb.pop_front();
                    if (bus.out_data !== it.exp) begin errors++; $display("FAIL round_value: got %h want %h", bus.out_data, it.exp); end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back('{exps[idx], cyc});
                idx++;
            end
            guard++;
        end
        checks++;
        if (guard >= 50) begin errors++; $display("FAIL round_timeout: got %0d pending want 0", sb.size()); end
    endtask

    task automatic test_extremes();
        logic [31:0] vals[3];
        logic [31:0] exps[3];
        item_t it;
        int idx = 0;
        int guard = 0;
        vals = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FF00};
        exps = '{32'h4F00_0000, 32'hCF00_0000, 32'hC380_0000};
        sb.delete();
        while ((idx < 3 || sb.size() > 0) && guard < 50) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            bus.in_valid  = (idx < 3);
            bus.in_data   = (idx < 3) ? vals[idx] : 32'd0;
            #1;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL extreme_spurious: got %h want none", bus.out_data);
                end else begin
                    it = sb.pop_front();
                    if (bus.out_data !== it.exp) begin errors++; $display("FAIL extreme_value: got %h want %h", bus.out_data, it.exp); end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back('{exps[idx], cyc});
                idx++;
            end
            guard++;
        end
        checks++;
        if (guard >= 50) begin errors++; $display("FAIL extreme_timeout: got %0d pending want 0", sb.size()); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exps[4];
        item_t it;
        int idx = 0;
        int k = 0;
        int popped = 0;
        exps = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
        sb.delete();
        while ((idx < 4 || sb.size() > 0) && k < 60) begin
            @(negedge clk);
            bus.out_ready = (k >= 5);
            bus.in_valid  = (idx < 4);
            bus.in_data   = 32'(idx + 1);
            #1;
            if (k >= 2 && k < 5) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h3F80_0000) begin
                    errors++; $display("FAIL bp_hold: got v=%b %h want v=1 3f800000", bus.out_valid, bus.out_data);
                end
            end
            if (k == 4) begin
                checks++;
                if (idx != 2 || bus.in_ready !== 1'b0) begin
                    errors++; $display("FAIL bp_stall: got accepted=%0d in_ready=%b want 2 0", idx, bus.in_ready);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL bp_spurious: got %h want none", bus.out_data);
                end else begin
                    it = sb.pop_front();
                    popped++;
                    if (bus.out_data !== it.exp) begin errors++; $display("FAIL bp_order: got %h want %h", bus.out_data, it.exp); end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back('{exps[idx], cyc});
                idx++;
            end
            k++;
        end
        checks++;
        if (popped != 4) begin errors++; $display("FAIL bp_count: got %0d want 4", popped); end
    endtask

    task automatic test_reset_mid();
        int idx = 0;
        sb.delete();
        // Fill both stages while the consumer stalls.
        repeat (3) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            bus.in_valid  = (idx < 2);
            bus.in_data   = 32'(idx + 5);
            #1;
            if (bus.in_valid && bus.in_ready) idx++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL rstmid_full: got v=%b rdy=%b want 1 0", bus.out_valid, bus.in_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b want 0", bus.out_valid); end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b want 1", bus.in_ready); end
        repeat (5) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            #1;
            checks++;
            if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale: got %h want none", bus.out_data); end
        end
    endtask

    task automatic test_random();
        item_t it;
        int n = 10000;
        int idx = 0;
        int popped = 0;
        int guard = 0;
        logic [31:0] v;
        sb.delete();
        while ((idx < n || sb.size() > 0) && guard < 60000) begin
            @(negedge clk);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            bus.in_valid  = (idx < n) && ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 5))
                0: v = 32'($signed($urandom_range(0, 600)) - 300);
                1: v = 32'h0100_0000 + 32'($urandom_range(0, 15));
                2: v = ($urandom_range(0, 1) == 1) ? 32'h7FFF_FFFF - 32'($urandom_range(0, 200))
                                                   : 32'h8000_0000 + 32'($urandom_range(0, 200));
                default: v = $urandom;
            endcase
            bus.in_data = v;
            #1;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL rand_spurious: got %h want none", bus.out_data);
                end else begin
                    it = sb.pop_front();
                    popped++;
                    if (bus.out_data !== it.exp) begin errors++; $display("FAIL rand_value: got %h want %h", bus.out_data, it.exp); end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back('{ref_itof(v), cyc});
                idx++;
            end
            guard++;
        end
        checks++;
        if (popped != n) begin errors++; $display("FAIL rand_count: got %0d want %0d", popped, n); end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'd0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_rounding();
        test_extremes();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
